buffered_line_router: RTL and testbench

//   Parametrised successor to the 1-D interconnect node: buffered 3-port router
//   (left neighbour, right neighbour, local self) for a linear chain of nodes.

---
 rtl/buffered_line_router_if.sv | 55 +++++
 rtl/buffered_line_router.sv | 221 ++++++++++++++++++++++
 tb/tb_buffered_line_router.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffered_line_router_if.sv
// Bus bundle for the three-port line router.
// Carries the left / right / self input channels (data, valid, ready),
// the matching output channels and the per-output source tags.
// The router sits on the slave modport; neighbours and the local
// client (or a testbench) sit on the master modport.
interface buffered_line_router_if #(
    parameter int WIDTH = 32
);
    // Input channels: flits arriving from the left neighbour, right neighbour and self
    logic [WIDTH-1:0] shiftInLeftData;
    logic [WIDTH-1:0] shiftInRightData;
    logic [WIDTH-1:0] shiftInData;
    logic             shiftInLeftCS;
    logic             shiftInRightCS;
    logic             shiftInCS;
    logic             shiftInLeftReady;
    logic             shiftInRightReady;
    logic             shiftInReady;

    // Output channels: flits leaving toward the left neighbour, right neighbour and self
    logic [WIDTH-1:0] shiftOutLeftData;
    logic [WIDTH-1:0] shiftOutRightData;
    logic [WIDTH-1:0] shiftOutData;
    logic             shiftOutLeftCS;
    logic             shiftOutRightCS;
    logic             shiftOutCS;
    logic             shiftOutLeftReady;
    logic             shiftOutRightReady;
    logic             shiftOutReady;

    // Which input produced the flit currently held in each output register
    logic [1:0]       leftDataSource;
    logic [1:0]       rightDataSource;
    logic [1:0]       selfDataSource;

    modport slave (
        input  shiftInLeftData, shiftInRightData, shiftInData,
        input  shiftInLeftCS, shiftInRightCS, shiftInCS,
        output shiftInLeftReady, shiftInRightReady, shiftInReady,
        output shiftOutLeftData, shiftOutRightData, shiftOutData,
        output shiftOutLeftCS, shiftOutRightCS, shiftOutCS,
        input  shiftOutLeftReady, shiftOutRightReady, shiftOutReady,
        output leftDataSource, rightDataSource, selfDataSource
    );

    modport master (
        output shiftInLeftData, shiftInRightData, shiftInData,
        output shiftInLeftCS, shiftInRightCS, shiftInCS,
        input  shiftInLeftReady, shiftInRightReady, shiftInReady,
        input  shiftOutLeftData, shiftOutRightData, shiftOutData,
        input  shiftOutLeftCS, shiftOutRightCS, shiftOutCS,
        output shiftOutLeftReady, shiftOutRightReady, shiftOutReady,
        input  leftDataSource, rightDataSource, selfDataSource
    );
endinterface

// File: rtl/buffered_line_router.sv
// Buffered three-port router node for a linear chain.
// Every input (left, right, self) owns a small FIFO. The head of each FIFO
// is routed by its header: direction in the two MSBs, hop count just below.
// Each output is a registered valid/ready stage fed by a round-robin arbiter
// over the three FIFO heads. Heads bound for different outputs move in the
// same cycle; a losing head simply waits in its FIFO, so nothing is dropped
// and per-input order is preserved.
// Port index convention used internally: 0 = left, 1 = right, 2 = self.
module buffered_line_router #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int HOP_W = 4
) (
    input logic                   shiftInCLK,
    input logic                   resetN,
    buffered_line_router_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NP = 3;

    localparam logic [1:0] PORT_L = 2'd0;
    localparam logic [1:0] PORT_R = 2'd1;
    localparam logic [1:0] PORT_S = 2'd2;

    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

    // Flattened views of the bus so the datapath can be written as loops
    logic [WIDTH-1:0] in_data   [NP];
    logic [NP-1:0]    in_cs;
    logic [NP-1:0]    out_ready;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_q     [NP][DEPTH];
    logic [WIDTH-1:0] mem_d     [NP][DEPTH];
    logic [AW-1:0]    wr_ptr_q  [NP];
    logic [AW-1:0]    wr_ptr_d  [NP];
    logic [AW-1:0]    rd_ptr_q  [NP];
    logic [AW-1:0]    rd_ptr_d  [NP];
    logic [CW-1:0]    count_q   [NP];
    logic [CW-1:0]    count_d   [NP];

    logic [NP-1:0]    in_ready;
    logic [NP-1:0]    push;
    logic [NP-1:0]    pop;
    logic [NP-1:0]    head_valid;

    // Decoded FIFO heads
    logic [WIDTH-1:0] head_data [NP];
    logic [WIDTH-1:0] head_fwd  [NP];
    logic [1:0]       head_dest [NP];

    // Arbitration
    logic [NP-1:0]    req       [NP];
    logic [NP-1:0]    grant     [NP];
    logic [NP-1:0]    can_load;

    // Output registers and round-robin pointers
    logic             out_cs_q   [NP];
    logic             out_cs_d   [NP];
    logic [WIDTH-1:0] out_data_q [NP];
    logic [WIDTH-1:0] out_data_d [NP];
    logic [1:0]       out_src_q  [NP];
    logic [1:0]       out_src_d  [NP];
    logic [1:0]       rr_ptr_q   [NP];
    logic [1:0]       rr_ptr_d   [NP];

    // Round-robin pick: first requester found starting at the pointer, one-hot result
    function automatic logic [NP-1:0] rr_grant(input logic [NP-1:0] r, input logic [1:0] ptr);
        logic [NP-1:0] g;
        int            idx;
        g = '0;
        for (int k = 0; k < NP; k++) begin
            idx = (int'(ptr) + k) % NP;
            if (g == '0 && r[idx[1:0]]) begin
                g[idx[1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

    // Gather the bus inputs into indexed arrays
    always_comb begin
        in_data[0]   = bus.shiftInLeftData;
        in_data[1]   = bus.shiftInRightData;
        in_data[2]   = bus.shiftInData;
        in_cs        = {bus.shiftInCS, bus.shiftInRightCS, bus.shiftInLeftCS};
        out_ready    = {bus.shiftOutReady, bus.shiftOutRightReady, bus.shiftOutLeftReady};
    end

    // FIFO status: ready comes only from the registered count, so it never depends on CS
    always_comb begin
        in_ready   = '0;
        push       = '0;
        head_valid = '0;
        for (int i = 0; i < NP; i++) begin
            in_ready[i]   = (count_q[i] != CW'(DEPTH));
            push[i]       = in_cs[i] && in_ready[i];
            head_valid[i] = (count_q[i] != '0);
        end
    end

    // Decode each FIFO head: pick its output and decrement the hop count when it travels on
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            head_data[i] = mem_q[i][rd_ptr_q[i]];
            head_fwd[i]  = head_data[i];
            head_dest[i] = PORT_S;
            if (head_data[i][WIDTH-3 -: HOP_W] != '0) begin
                if (head_data[i][WIDTH-1 -: 2] == DIR_LEFT) begin
                    head_dest[i] = PORT_L;
                    head_fwd[i][WIDTH-3 -: HOP_W] = head_data[i][WIDTH-3 -: HOP_W] - HOP_W'(1);
                end else if (head_data[i][WIDTH-1 -: 2] == DIR_RIGHT) begin
                    head_dest[i] = PORT_R;
                    head_fwd[i][WIDTH-3 -: HOP_W] = head_data[i][WIDTH-3 -: HOP_W] - HOP_W'(1);
                end
            end
        end
    end

    // Per-output arbitration; an output only grants when its register is free or draining
    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            req[o] = '0;
            for (int i = 0; i < NP; i++) begin
                req[o][i] = head_valid[i] && (head_dest[i] == 2'(o));
            end
            can_load[o] = !out_cs_q[o] || out_ready[o];
            grant[o]    = can_load[o] ? rr_grant(req[o], rr_ptr_q[o]) : '0;
        end
        for (int i = 0; i < NP; i++) begin
            pop[i] = grant[0][i] || grant[1][i] || grant[2][i];
        end
    end

    // FIFO next state: write at the tail, advance the head on a grant, track occupancy
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NP; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            end
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Output register next state: load the winner, otherwise empty out after a handshake
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            out_cs_d[o]   = out_cs_q[o];
            out_data_d[o] = out_data_q[o];
            out_src_d[o]  = out_src_q[o];
            rr_ptr_d[o]   = rr_ptr_q[o];
            if (grant[o] != '0) begin
                out_cs_d[o] = 1'b1;
                for (int i = 0; i < NP; i++) begin
                    if (grant[o][i]) begin
                        out_data_d[o] = head_fwd[i];
                        out_src_d[o]  = 2'(i);
                        rr_ptr_d[o]   = (i == NP - 1) ? PORT_L : 2'(i + 1);
                    end
                end
            end else if (out_cs_q[o] && out_ready[o]) begin
                out_cs_d[o] = 1'b0;
            end
        end
    end

    // FIFO storage has no reset; the pointers and counts below decide what is valid
    always_ff @(posedge shiftInCLK) begin
        mem_q <= mem_d;
    end

    // Control state: asynchronous reset flushes every FIFO and clears every output stage
    always_ff @(posedge shiftInCLK or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                out_cs_q[i]   <= 1'b0;
                out_data_q[i] <= '0;
                out_src_q[i]  <= PORT_L;
                rr_ptr_q[i]   <= PORT_L;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_cs_q   <= out_cs_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Drive the bus from the registered state
    assign bus.shiftInLeftReady   = in_ready[0];
    assign bus.shiftInRightReady  = in_ready[1];
    assign bus.shiftInReady       = in_ready[2];

    assign bus.shiftOutLeftData   = out_data_q[0];
    assign bus.shiftOutRightData  = out_data_q[1];
    assign bus.shiftOutData       = out_data_q[2];
    assign bus.shiftOutLeftCS     = out_cs_q[0];
    assign bus.shiftOutRightCS    = out_cs_q[1];
    assign bus.shiftOutCS         = out_cs_q[2];
    assign bus.leftDataSource     = out_src_q[0];
    assign bus.rightDataSource    = out_src_q[1];
    assign bus.selfDataSource     = out_src_q[2];

endmodule

// File: tb/tb_buffered_line_router.sv
// Testbench for buffered_line_router (WIDTH=32, DEPTH=4, HOP_W=4).
// Directed scenarios with exact cycle expectations, then randomized traffic
// scored against a per-(output, source) queue model built from the routing rules.
module tb_buffered_line_router;

    logic clk;
    logic rst_n;

    int check_count;
    int error_count;

    // Expected flits, one queue per (output, source) pair: index = out*3 + src
    logic [31:0] expq [9][$];

    // Output held under back-pressure last cycle, and what it showed then
    logic        hold_valid [3];
    logic [31:0] hold_data  [3];
    logic [31:0] hold_src   [3];

    buffered_line_router_if #(.WIDTH(32)) ifc ();

    buffered_line_router #(
        .WIDTH (32),
        .DEPTH (4),
        .HOP_W (4)
    ) dut (
        .shiftInCLK (clk),
        .resetN     (rst_n),
        .bus        (ifc.slave)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still ends with a visible failure
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] cs, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [2:0] rdy);
        ifc.shiftInLeftCS      = cs[0];
        ifc.shiftInRightCS     = cs[1];
        ifc.shiftInCS          = cs[2];
        ifc.shiftInLeftData    = d0;
        ifc.shiftInRightData   = d1;
        ifc.shiftInData        = d2;
        ifc.shiftOutLeftReady  = rdy[0];
        ifc.shiftOutRightReady = rdy[1];
        ifc.shiftOutReady      = rdy[2];
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] get_out_cs(input int o);
        case (o)
            0:       return {31'd0, ifc.shiftOutLeftCS};
            1:       return {31'd0, ifc.shiftOutRightCS};
            default: return {31'd0, ifc.shiftOutCS};
        endcase
    endfunction

    function automatic logic [31:0] get_out_data(input int o);
        case (o)
            0:       return ifc.shiftOutLeftData;
            1:       return ifc.shiftOutRightData;
            default: return ifc.shiftOutData;
        endcase
    endfunction

    function automatic logic [31:0] get_out_src(input int o);
        case (o)
            0:       return {30'd0, ifc.leftDataSource};
            1:       return {30'd0, ifc.rightDataSource};
            default: return {30'd0, ifc.selfDataSource};
        endcase
    endfunction

    function automatic logic [31:0] get_in_ready(input int i);
        case (i)
            0:       return {31'd0, ifc.shiftInLeftReady};
            1:       return {31'd0, ifc.shiftInRightReady};
            default: return {31'd0, ifc.shiftInReady};
        endcase
    endfunction

    // Routing rule: dir 01 / 10 with hops>0 travel left / right with one hop used, else deliver to self
    function automatic void route_flit(input logic [31:0] f, output int dest, output logic [31:0] nf);
        logic [1:0] dir;
        logic [3:0] hops;
        dir  = f[31:30];
        hops = f[29:26];
        nf   = f;
        dest = 2;
        if (hops != 4'd0 && dir == 2'b01) begin
            dest      = 0;
            nf[29:26] = hops - 4'd1;
        end else if (hops != 4'd0 && dir == 2'b10) begin
            dest      = 1;
            nf[29:26] = hops - 4'd1;
        end
    endfunction

    function automatic logic [31:0] rand_flit();
        logic [31:0] f;
        f = $urandom;
        if ($urandom_range(1) == 1) begin
            f[29:26] = 4'($urandom_range(2));
        end
        return f;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 9; k++) begin
            expq[k].delete();
        end
        for (int o = 0; o < 3; o++) begin
            hold_valid[o] = 1'b0;
            hold_data[o]  = '0;
            hold_src[o]   = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_model();
    endtask

    task automatic check_reset_state(input string tag);
        for (int o = 0; o < 3; o++) begin
            checkOutput($sformatf("%s_out_cs%0d", tag, o), get_out_cs(o), 32'd0);
            checkOutput($sformatf("%s_out_data%0d", tag, o), get_out_data(o), 32'd0);
            checkOutput($sformatf("%s_out_src%0d", tag, o), get_out_src(o), 32'd0);
            checkOutput($sformatf("%s_in_ready%0d", tag, o), get_in_ready(o), 32'd1);
        end
    endtask

    // One randomized cycle: check held outputs, drive new inputs, score handshakes, advance
    task automatic randomCycle(input int push_pct, input int ready_pct);
        logic [2:0]  cs_v;
        logic [2:0]  rdy_v;
        logic [31:0] d [3];
        logic [31:0] o_cs;
        logic [31:0] o_data;
        logic [31:0] o_src;
        logic [31:0] nf;
        int          dest;
        int          k;
        for (int o = 0; o < 3; o++) begin
            if (hold_valid[o]) begin
                checkOutput($sformatf("hold_cs%0d", o), get_out_cs(o), 32'd1);
                checkOutput($sformatf("hold_data%0d", o), get_out_data(o), hold_data[o]);
                checkOutput($sformatf("hold_src%0d", o), get_out_src(o), hold_src[o]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cs_v[i]  = (int'($urandom_range(99)) < push_pct);
            d[i]     = rand_flit();
            rdy_v[i] = (int'($urandom_range(99)) < ready_pct);
        end
        applyStimulus(cs_v, d[0], d[1], d[2], rdy_v);
        for (int o = 0; o < 3; o++) begin
            o_cs   = get_out_cs(o);
            o_data = get_out_data(o);
            o_src  = get_out_src(o);
            if (o_cs == 32'd1 && rdy_v[o]) begin
                checkOutput($sformatf("src_range%0d", o), {31'd0, (o_src < 32'd3)}, 32'd1);
                if (o_src < 32'd3) begin
                    k = o * 3 + int'(o_src);
                    checkOutput($sformatf("sb_avail%0d", o), {31'd0, (expq[k].size() > 0)}, 32'd1);
                    if (expq[k].size() > 0) begin
                        checkOutput($sformatf("sb_data%0d", o), o_data, expq[k].pop_front());
                    end
                end
            end
            hold_valid[o] = (o_cs == 32'd1) && !rdy_v[o];
            hold_data[o]  = o_data;
            hold_src[o]   = o_src;
        end
        for (int i = 0; i < 3; i++) begin
            if (cs_v[i] && get_in_ready(i) == 32'd1) begin
                route_flit(d[i], dest, nf);
                expq[dest * 3 + i].push_back(nf);
            end
        end
        tick();
    endtask

    // Main sequence: directed scenarios, then randomized traffic with a mid-run reset
    initial begin
        int          accepted;
        int          nxt;
        int          remaining;
        logic [31:0] got [$];

        check_count = 0;
        error_count = 0;
        rst_n = 1'b0;
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        clear_model();
        repeat (2) tick();
        check_reset_state("por");
        rst_n = 1'b1;
        tick();

        $display("[TB] directed: self flit to left, three hops");
        do_reset();
        applyStimulus(3'b100, 32'd0, 32'd0, 32'h4C000000, 3'b111);
        tick();
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        checkOutput("a_latency_cs", get_out_cs(0), 32'd0);
        tick();
        checkOutput("a_left_cs", get_out_cs(0), 32'd1);
        checkOutput("a_left_data", get_out_data(0), 32'h48000000);
        checkOutput("a_left_src", get_out_src(0), 32'd2);
        tick();
        checkOutput("a_left_drained", get_out_cs(0), 32'd0);

        $display("[TB] directed: left flit with zero hops delivered to self");
        do_reset();
        applyStimulus(3'b001, 32'h80000000, 32'd0, 32'd0, 3'b111);
        tick();
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        tick();
        checkOutput("b_self_cs", get_out_cs(2), 32'd1);
        checkOutput("b_self_data", get_out_data(2), 32'h80000000);
        checkOutput("b_self_src", get_out_src(2), 32'd0);
        checkOutput("b_right_idle", get_out_cs(1), 32'd0);

        $display("[TB] directed: left and right contend for the left output");
        do_reset();
        applyStimulus(3'b011, 32'h44000000, 32'h44000000, 32'd0, 3'b111);
        tick();
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        tick();
        checkOutput("c_first_cs", get_out_cs(0), 32'd1);
        checkOutput("c_first_data", get_out_data(0), 32'h40000000);
        checkOutput("c_first_src", get_out_src(0), 32'd0);
        tick();
        checkOutput("c_second_cs", get_out_cs(0), 32'd1);
        checkOutput("c_second_data", get_out_data(0), 32'h40000000);
        checkOutput("c_second_src", get_out_src(0), 32'd1);
        tick();
        checkOutput("c_done_cs", get_out_cs(0), 32'd0);

        $display("[TB] directed: right output stalled, self fills buffering");
        do_reset();
        accepted = 0;
        nxt = 1;
        for (int c = 0; c < 12; c++) begin
            if (nxt <= 6) begin
                applyStimulus(3'b100, 32'd0, 32'd0, 32'h84000000 | 32'(nxt), 3'b101);
                if (get_in_ready(2) == 32'd1) begin
                    accepted++;
                    nxt++;
                end
            end else begin
                applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b101);
            end
            tick();
        end
        checkOutput("d_accepted", 32'(accepted), 32'd5);
        checkOutput("d_in_ready", get_in_ready(2), 32'd0);
        checkOutput("d_right_held", get_out_data(1), 32'h80000001);
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        got.delete();
        for (int c = 0; c < 12; c++) begin
            if (get_out_cs(1) == 32'd1) begin
                got.push_back(get_out_data(1));
            end
            tick();
        end
        checkOutput("d_out_count", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got.size()) begin
                checkOutput($sformatf("d_order%0d", k), got[k], 32'h80000001 + 32'(k));
            end
        end
        checkOutput("d_in_ready_back", get_in_ready(2), 32'd1);

        $display("[TB] directed: flits to distinct outputs move together");
        do_reset();
        applyStimulus(3'b101, 32'h80000000, 32'd0, 32'h84000000, 3'b111);
        tick();
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        checkOutput("e_self_early", get_out_cs(2), 32'd0);
        checkOutput("e_right_early", get_out_cs(1), 32'd0);
        tick();
        checkOutput("e_self_cs", get_out_cs(2), 32'd1);
        checkOutput("e_right_cs", get_out_cs(1), 32'd1);
        checkOutput("e_self_data", get_out_data(2), 32'h80000000);
        checkOutput("e_right_data", get_out_data(1), 32'h80000000);
        checkOutput("e_self_src", get_out_src(2), 32'd0);
        checkOutput("e_right_src", get_out_src(1), 32'd2);

        $display("[TB] random: congested traffic then reset mid-flight");
        do_reset();
        for (int c = 0; c < 400; c++) begin
            randomCycle(70, 30);
        end
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        applyStimulus(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111);
        tick();
        tick();
        check_reset_state("held");
        applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 3'b111);
        rst_n = 1'b1;
        clear_model();
        tick();

        $display("[TB] random: mixed traffic after reset");
        for (int c = 0; c < 800; c++) begin
            randomCycle(50, 60);
        end
        for (int c = 0; c < 60; c++) begin
            randomCycle(0, 100);
        end
        remaining = 0;
        for (int k = 0; k < 9; k++) begin
            remaining += expq[k].size();
        end
        checkOutput("drain_remaining", 32'(remaining), 32'd0);
        for (int o = 0; o < 3; o++) begin
            checkOutput($sformatf("drain_out_cs%0d", o), get_out_cs(o), 32'd0);
            checkOutput($sformatf("drain_in_ready%0d", o), get_in_ready(o), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
